// File: rtl/ysyx_23060201_mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
//   arb_state_e      : FSM state encoding (IDLE -> SREQ -> SRSP -> MRSP)
//   WMASK_W          : byte write-mask width
//   DEFAULT_TIMEOUT  : default slave-wait limit in cycles (0 disables)
//   cnt_width()      : width of the timeout counter for a given limit
package ysyx_23060201_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SREQ = 2'd1,
    ST_SRSP = 2'd2,
    ST_MRSP = 2'd3
  } arb_state_e;

  localparam int WMASK_W         = 8;
  localparam int DEFAULT_TIMEOUT = 255;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ysyx_23060201_mem_arb_rr_pick.sv
// Two-way round-robin picker.
//   valid0, valid1 : request bits from master 0 / master 1
//   last_grant     : index of the master served most recently
//   any_valid      : at least one request present
//   pick           : index of the winning master
module ysyx_23060201_mem_arb_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic any_valid,
  output logic pick
);

  assign any_valid = valid0 | valid1;

  // On a tie the master not served last wins; otherwise the lone requester.
  always_comb begin
    pick = 1'b0;
    if (valid0 && valid1) begin
      pick = ~last_grant;
    end else begin
      pick = valid1;
    end
  end

endmodule

// File: rtl/ysyx_23060201_mem_arb.sv
// Two-master (m0 = IFU fetch, m1 = LSU) arbiter in front of one shared memory.
// One transaction outstanding: IDLE -> SREQ -> SRSP -> MRSP -> IDLE.
//   clk, rst (async, active-low)
//   m{0,1}_req_*  : master request channel (valid/ready, addr, wen, wdata, wmask)
//   m{0,1}_rsp_*  : master response channel (valid/ready, rdata, rsp_err)
//   s_req_*, s_*  : slave request channel with latched fields
//   s_rsp_*       : slave response channel
//   grant         : master owning the current/last transaction
//   busy          : FSM not in IDLE
module ysyx_23060201_mem_arb
  import ysyx_23060201_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req_valid,
  output logic               m0_req_ready,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic               m0_wen,
  input  logic [DATA_W-1:0]  m0_wdata,
  input  logic [WMASK_W-1:0] m0_wmask,
  output logic               m0_rsp_valid,
  input  logic               m0_rsp_ready,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m0_rsp_err,
  input  logic               m1_req_valid,
  output logic               m1_req_ready,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic               m1_wen,
  input  logic [DATA_W-1:0]  m1_wdata,
  input  logic [WMASK_W-1:0] m1_wmask,
  output logic               m1_rsp_valid,
  input  logic               m1_rsp_ready,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic               m1_rsp_err,
  output logic               s_req_valid,
  input  logic               s_req_ready,
  output logic [ADDR_W-1:0]  s_addr,
  output logic               s_wen,
  output logic [DATA_W-1:0]  s_wdata,
  output logic [WMASK_W-1:0] s_wmask,
  input  logic               s_rsp_valid,
  output logic               s_rsp_ready,
  input  logic [DATA_W-1:0]  s_rdata,
  output logic               grant,
  output logic               busy
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_e         state_reg, state_next;
  logic               grant_reg, last_grant_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic               wen_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [WMASK_W-1:0] wmask_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   tmo_cnt_reg;

  logic pick_valid, pick;
  logic accept, tmo_hit, m_rsp_fire;

  ysyx_23060201_mem_arb_rr_pick u_rr_pick (
    .valid0     (m0_req_valid),
    .valid1     (m1_req_valid),
    .last_grant (last_grant_reg),
    .any_valid  (pick_valid),
    .pick       (pick)
  );

  assign accept     = (state_reg == ST_IDLE) && pick_valid;
  // Fires in the cycle whose increment would make the count reach TIMEOUT.
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt_reg >= CNT_W'(TIMEOUT - 1));
  assign m_rsp_fire = (state_reg == ST_MRSP) && (grant_reg ? m1_rsp_ready : m0_rsp_ready);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; slave handshakes are tested before the timeout so they win a tie.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (pick_valid) state_next = ST_SREQ;
      ST_SREQ: begin
        if (s_req_ready)  state_next = ST_SRSP;
        else if (tmo_hit) state_next = ST_MRSP;
      end
      ST_SRSP: begin
        if (s_rsp_valid)  state_next = ST_MRSP;
        else if (tmo_hit) state_next = ST_MRSP;
      end
      ST_MRSP: if (m_rsp_fire) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers. last_grant resets to 1 so that m0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      wen_reg        <= 1'b0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      tmo_cnt_reg    <= '0;
    end else begin
      if (accept) begin
        grant_reg   <= pick;
        addr_reg    <= pick ? m1_addr  : m0_addr;
        wen_reg     <= pick ? m1_wen   : m0_wen;
        wdata_reg   <= pick ? m1_wdata : m0_wdata;
        wmask_reg   <= pick ? m1_wmask : m0_wmask;
        rdata_reg   <= '0;
        err_reg     <= 1'b0;
        tmo_cnt_reg <= '0;
      end
      if ((state_reg == ST_SREQ || state_reg == ST_SRSP) && TIMEOUT != 0) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
      if (state_reg == ST_SREQ && !s_req_ready && tmo_hit) begin
        rdata_reg <= '0;
        err_reg   <= 1'b1;
      end
      if (state_reg == ST_SRSP) begin
        if (s_rsp_valid) begin
          rdata_reg <= s_rdata;
          err_reg   <= 1'b0;
        end else if (tmo_hit) begin
          rdata_reg <= '0;
          err_reg   <= 1'b1;
        end
      end
      if (m_rsp_fire) last_grant_reg <= grant_reg;
    end
  end

  // Outputs
  always_comb begin
    m0_req_ready = accept && !pick;
    m1_req_ready = accept && pick;
    s_req_valid  = (state_reg == ST_SREQ);
    s_rsp_ready  = (state_reg == ST_SRSP);
    m0_rsp_valid = (state_reg == ST_MRSP) && !grant_reg;
    m1_rsp_valid = (state_reg == ST_MRSP) && grant_reg;
    m0_rdata     = m0_rsp_valid ? rdata_reg : '0;
    m1_rdata     = m1_rsp_valid ? rdata_reg : '0;
    m0_rsp_err   = m0_rsp_valid && err_reg;
    m1_rsp_err   = m1_rsp_valid && err_reg;
    busy         = (state_reg != ST_IDLE);
  end

  assign grant   = grant_reg;
  assign s_addr  = addr_reg;
  assign s_wen   = wen_reg;
  assign s_wdata = wdata_reg;
  assign s_wmask = wmask_reg;

endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
module tb_ysyx_23060201_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req_valid, m0_wen, m0_rsp_ready;
  logic [31:0] m0_addr, m0_wdata;
  logic [7:0]  m0_wmask;
  logic        m1_req_valid, m1_wen, m1_rsp_ready;
  logic [31:0] m1_addr, m1_wdata;
  logic [7:0]  m1_wmask;
  logic        s_req_ready, s_rsp_valid;
  logic [31:0] s_rdata;

  // Outputs of the default-TIMEOUT instance
  logic        m0_req_ready, m0_rsp_valid, m0_rsp_err;
  logic        m1_req_ready, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        s_req_valid, s_rsp_ready, s_wen, grant, busy;
  logic [7:0]  s_wmask;

  // Outputs of the TIMEOUT=4 instance
  logic        t_m0_req_ready, t_m0_rsp_valid, t_m0_rsp_err;
  logic        t_m1_req_ready, t_m1_rsp_valid, t_m1_rsp_err;
  logic [31:0] t_m0_rdata, t_m1_rdata, t_s_addr, t_s_wdata;
  logic        t_s_req_valid, t_s_rsp_ready, t_s_wen, t_grant, t_busy;
  logic [7:0]  t_s_wmask;

  always #5 clk = ~clk;

  ysyx_23060201_mem_arb dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata),
    .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata),
    .m1_rsp_err(m1_rsp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  ysyx_23060201_mem_arb #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(t_m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rsp_valid(t_m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rdata(t_m0_rdata),
    .m0_rsp_err(t_m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(t_m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rsp_valid(t_m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rdata(t_m1_rdata),
    .m1_rsp_err(t_m1_rsp_err),
    .s_req_valid(t_s_req_valid), .s_req_ready(s_req_ready), .s_addr(t_s_addr),
    .s_wen(t_s_wen), .s_wdata(t_s_wdata), .s_wmask(t_s_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(t_s_rsp_ready), .s_rdata(s_rdata),
    .grant(t_grant), .busy(t_busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int overlap_cnt = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // s_req_valid and s_rsp_ready must never overlap on either instance.
  always @(negedge clk) begin
    if (rst && ((s_req_valid && s_rsp_ready) || (t_s_req_valid && t_s_rsp_ready)))
      overlap_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 0; m0_wen = 0; m0_rsp_ready = 0; m0_addr = 0; m0_wdata = 0; m0_wmask = 0;
    m1_req_valid = 0; m1_wen = 0; m1_rsp_ready = 0; m1_addr = 0; m1_wdata = 0; m1_wmask = 0;
    s_req_ready = 0; s_rsp_valid = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    step();
    step();
    rst = 1;
  endtask

  initial begin
    int hs;
    idle_inputs();

    // ---- reset state ----
    step();
    #1;
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_grant", grant, 0);
    expect_eq("rst_sreqv", s_req_valid, 0);
    expect_eq("rst_saddr", s_addr, 0);

    // ---- single m0 read, zero-wait slave ----
    do_reset();
    m0_req_valid = 1; m0_addr = 32'h8000_0000;
    s_req_ready = 1; s_rsp_valid = 1; s_rdata = 32'h0000_0413;
    #1;
    expect_eq("rd_c0_m0rdy", m0_req_ready, 1);
    expect_eq("rd_c0_m1rdy", m1_req_ready, 0);
    expect_eq("rd_c0_busy", busy, 0);
    step(); m0_req_valid = 0; m0_addr = 32'h0; #1;
    expect_eq("rd_c1_sreqv", s_req_valid, 1);
    expect_eq("rd_c1_saddr", s_addr, 32'h8000_0000);
    expect_eq("rd_c1_swen", s_wen, 0);
    expect_eq("rd_c1_srspr", s_rsp_ready, 0);
    step(); #1;
    expect_eq("rd_c2_srspr", s_rsp_ready, 1);
    expect_eq("rd_c2_sreqv", s_req_valid, 0);
    expect_eq("rd_c2_m0v", m0_rsp_valid, 0);
    step(); #1;
    expect_eq("rd_c3_m0v", m0_rsp_valid, 1);
    expect_eq("rd_c3_rdata", m0_rdata, 32'h0000_0413);
    expect_eq("rd_c3_grant", grant, 0);
    expect_eq("rd_c3_err", m0_rsp_err, 0);
    expect_eq("rd_c3_m1v", m1_rsp_valid, 0);
    expect_eq("rd_c3_m1rd", m1_rdata, 0);
    m0_rsp_ready = 1;
    step(); #1;
    expect_eq("rd_c4_busy", busy, 0);
    expect_eq("rd_c4_m0v", m0_rsp_valid, 0);
    $display("txn single m0 read done");

    // ---- tie from reset, then repeat tie ----
    do_reset();
    s_req_ready = 1; s_rsp_valid = 1; s_rdata = 32'hA5A5_0001;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    m0_req_valid = 1; m0_addr = 32'h0000_1000;
    m1_req_valid = 1; m1_addr = 32'h0000_2000;
    #1;
    expect_eq("rr_c0_m0rdy", m0_req_ready, 1);
    expect_eq("rr_c0_m1rdy", m1_req_ready, 0);
    step(); m0_req_valid = 0; #1;
    expect_eq("rr_c1_m1rdy", m1_req_ready, 0);
    expect_eq("rr_c1_saddr", s_addr, 32'h0000_1000);
    step(); #1;
    step(); #1;
    expect_eq("rr_c3_m0v", m0_rsp_valid, 1);
    expect_eq("rr_c3_m1rdy", m1_req_ready, 0);
    step(); #1;
    expect_eq("rr_c4_m1rdy", m1_req_ready, 1);
    step(); m1_req_valid = 0; #1;
    expect_eq("rr_c5_grant", grant, 1);
    expect_eq("rr_c5_saddr", s_addr, 32'h0000_2000);
    step(); #1;
    step(); #1;
    expect_eq("rr_c7_m1v", m1_rsp_valid, 1);
    expect_eq("rr_c7_m1rd", m1_rdata, 32'hA5A5_0001);
    expect_eq("rr_c7_m0v", m0_rsp_valid, 0);
    step();
    m0_req_valid = 1; m1_req_valid = 1; #1;
    expect_eq("rr_tie2_m0rdy", m0_req_ready, 1);
    expect_eq("rr_tie2_m1rdy", m1_req_ready, 0);
    $display("txn round-robin ties done");

    // ---- m1 write, slave req_ready delayed 5 cycles ----
    do_reset();
    s_rsp_valid = 1; s_rdata = 32'h1234_5678; m1_rsp_ready = 1;
    m1_req_valid = 1; m1_wen = 1; m1_addr = 32'h8000_1000;
    m1_wdata = 32'hDEAD_BEEF; m1_wmask = 8'h0F;
    #1;
    expect_eq("wr_c0_m1rdy", m1_req_ready, 1);
    hs = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      m1_req_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wmask = 0; m1_wen = 0;
      #1;
      if (s_req_valid && s_req_ready) hs++;
      expect_eq($sformatf("wr_c%0d_stable", c),
                {s_req_valid, s_wen, s_wmask, s_addr[11:0], s_wdata},
                {1'b1, 1'b1, 8'h0F, 12'h000, 32'hDEAD_BEEF});
      expect_eq($sformatf("wr_c%0d_saddr", c), s_addr, 32'h8000_1000);
    end
    step(); s_req_ready = 1; #1;
    if (s_req_valid && s_req_ready) hs++;
    expect_eq("wr_c6_sreqv", s_req_valid, 1);
    step(); #1;
    if (s_req_valid && s_req_ready) hs++;
    expect_eq("wr_c7_srspr", s_rsp_ready, 1);
    step(); #1;
    if (s_req_valid && s_req_ready) hs++;
    expect_eq("wr_c8_m1v", m1_rsp_valid, 1);
    expect_eq("wr_c8_rdata", m1_rdata, 32'h1234_5678);
    expect_eq("wr_c8_err", m1_rsp_err, 0);
    expect_eq("wr_handshakes", hs, 1);
    $display("txn m1 delayed write done");

    // ---- TIMEOUT=4, slave never responds ----
    do_reset();
    s_rdata = 32'hFFFF_FFFF;
    m0_req_valid = 1; m0_addr = 32'h8000_0040;
    #1;
    expect_eq("to_c0_m0rdy", t_m0_req_ready, 1);
    step(); m0_req_valid = 0; #1;
    expect_eq("to_c1_sreqv", t_s_req_valid, 1);
    step(); step(); step(); #1;
    expect_eq("to_c4_m0v", t_m0_rsp_valid, 0);
    expect_eq("to_c4_busy", t_busy, 1);
    step(); #1;
    expect_eq("to_c5_m0v", t_m0_rsp_valid, 1);
    expect_eq("to_c5_err", t_m0_rsp_err, 1);
    expect_eq("to_c5_rdata", t_m0_rdata, 0);
    expect_eq("to_c5_sreqv", t_s_req_valid, 0);
    m0_rsp_ready = 1;
    step(); #1;
    expect_eq("to_c6_busy", t_busy, 0);
    expect_eq("to_c6_m0v", t_m0_rsp_valid, 0);
    $display("txn timeout done");

    // ---- TIMEOUT=4, handshakes on the timeout cycles ----
    do_reset();
    m0_req_valid = 1; m0_addr = 32'h8000_0080; m0_rsp_ready = 1;
    step(); m0_req_valid = 0;
    step(); step();
    step(); s_req_ready = 1; #1;
    expect_eq("tie_c4_sreqv", t_s_req_valid, 1);
    step(); s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'hCAFE_0001; #1;
    expect_eq("tie_c5_srspr", t_s_rsp_ready, 1);
    expect_eq("tie_c5_m0v", t_m0_rsp_valid, 0);
    step(); #1;
    expect_eq("tie_c6_m0v", t_m0_rsp_valid, 1);
    expect_eq("tie_c6_err", t_m0_rsp_err, 0);
    expect_eq("tie_c6_rdata", t_m0_rdata, 32'hCAFE_0001);
    $display("txn timeout tie done");

    // ---- async reset during SRSP ----
    do_reset();
    s_req_ready = 1;
    m0_req_valid = 1; m0_addr = 32'h8000_00C0;
    step(); m0_req_valid = 0;
    step(); #1;
    expect_eq("ar_pre_srspr", s_rsp_ready, 1);
    rst = 0; #1;
    expect_eq("ar_busy", busy, 0);
    expect_eq("ar_srspr", s_rsp_ready, 0);
    expect_eq("ar_sreqv", s_req_valid, 0);
    expect_eq("ar_m0v", m0_rsp_valid, 0);
    expect_eq("ar_saddr", s_addr, 0);
    expect_eq("ar_grant", grant, 0);
    step(); step();
    rst = 1;
    m1_req_valid = 1; m1_addr = 32'h8000_2000; #1;
    expect_eq("ar_m1rdy", m1_req_ready, 1);
    step(); m1_req_valid = 0; #1;
    expect_eq("ar_grant1", grant, 1);
    expect_eq("ar_saddr1", s_addr, 32'h8000_2000);
    $display("txn reset mid-transaction done");

    // ---- m0 stalls response for 3 cycles while m1 waits ----
    do_reset();
    s_req_ready = 1; s_rsp_valid = 1; s_rdata = 32'h55AA_55AA;
    m0_req_valid = 1; m0_addr = 32'h8000_0100;
    step(); m0_req_valid = 0; m1_req_valid = 1; m1_addr = 32'h8000_3000;
    step();
    step(); s_rdata = 32'h1111_1111;
    for (int c = 3; c <= 5; c++) begin
      #1;
      expect_eq($sformatf("st_c%0d_m0v", c), m0_rsp_valid, 1);
      expect_eq($sformatf("st_c%0d_rdata", c), m0_rdata, 32'h55AA_55AA);
      expect_eq($sformatf("st_c%0d_m1rdy", c), m1_req_ready, 0);
      step();
    end
    m0_rsp_ready = 1; #1;
    expect_eq("st_c6_m0v", m0_rsp_valid, 1);
    expect_eq("st_c6_m1rdy", m1_req_ready, 0);
    step(); #1;
    expect_eq("st_c7_m0v", m0_rsp_valid, 0);
    expect_eq("st_c7_m1rdy", m1_req_ready, 1);
    $display("txn m0 stalled response done");

    expect_eq("sreq_srsp_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
